// File: rtl/alu_ctrl_stage_pkg.sv
// Shared definitions for the ALU control decode stage: ALU op codes,
// RV32 opcode constants, operand/result select encodings and the
// packed control word registered into ID/EX.
package alu_ctrl_stage_pkg;

   typedef enum logic [2:0] {
      ALU_PLUS  = 3'b000,
      ALU_MINUS = 3'b001,
      ALU_AND   = 3'b010,
      ALU_OR    = 3'b011,
      ALU_SLT   = 3'b101
   } alu_op_e;

   typedef enum logic [1:0] {
      A_SEL_RS1  = 2'b00,
      A_SEL_PC   = 2'b01,
      A_SEL_ZERO = 2'b10
   } a_sel_e;

   typedef enum logic [1:0] {
      RES_ALU = 2'b00,
      RES_MEM = 2'b01,
      RES_PC4 = 2'b10
   } result_src_e;

   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_I      = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   // Control half of the ID/EX register (immediate is held separately
   // because its width follows XLEN).
   typedef struct packed {
      alu_op_e     alu_control;
      a_sel_e      alu_a_sel;
      logic        alu_src_imm;
      logic [4:0]  rd;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      result_src_e result_src;
      logic        branch;
      logic        jump;
      logic        branch_ne;
      logic        valid;
      logic        illegal;
   } ctrl_t;

   // Opcodes whose encoding carries a destination register.
   function automatic logic writes_rd(input logic [6:0] opc);
      return (opc == OPC_R)   || (opc == OPC_I)     || (opc == OPC_LOAD) ||
             (opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_JAL)  ||
             (opc == OPC_JALR);
   endfunction

endpackage

// File: rtl/alu_ctrl_stage_if.sv
// ALU control bus between IF/ID (instruction in) and ID/EX (controls out).
// The master side is the decode stage; the slave side is the pipeline
// around it.
interface alu_ctrl_if #(
   parameter int XLEN = 32
);
   logic [31:0]     instr;
   logic            instr_valid;
   logic            stall;
   logic            flush;

   logic [2:0]      alu_control;
   logic [1:0]      alu_a_sel;
   logic            alu_src_imm;
   logic [XLEN-1:0] imm;
   logic [4:0]      rd;
   logic            reg_write;
   logic            mem_read;
   logic            mem_write;
   logic [1:0]      result_src;
   logic            branch;
   logic            jump;
   logic            branch_ne;
   logic            valid;
   logic            illegal;

   modport master (
      input  instr, instr_valid, stall, flush,
      output alu_control, alu_a_sel, alu_src_imm, imm, rd, reg_write,
             mem_read, mem_write, result_src, branch, jump, branch_ne,
             valid, illegal
   );

   modport slave (
      output instr, instr_valid, stall, flush,
      input  alu_control, alu_a_sel, alu_src_imm, imm, rd, reg_write,
             mem_read, mem_write, result_src, branch, jump, branch_ne,
             valid, illegal
   );
endinterface

// File: rtl/alu_ctrl_stage_alu_decoder.sv
// Combinational ALU-op decoder: maps opcode/funct3/funct7 to the 3-bit
// ALU operation and flags encodings this core does not support.
module alu_decoder
   import alu_ctrl_stage_pkg::*;
(
   input  logic [6:0] opcode_i,
   input  logic [2:0] funct3_i,
   input  logic [6:0] funct7_i,
   output alu_op_e    alu_control_o,
   output logic       illegal_o
);

   // Select the ALU operation and detect unsupported encodings.
   always_comb begin
      alu_control_o = ALU_PLUS;
      illegal_o     = 1'b0;
      case (opcode_i)
         OPC_R, OPC_I: begin
            case (funct3_i)
               3'b000: begin
                  if ((opcode_i == OPC_R) && funct7_i[5]) begin
                     alu_control_o = ALU_MINUS;
                  end
               end
               3'b111:         alu_control_o = ALU_AND;
               3'b110:         alu_control_o = ALU_OR;
               3'b010, 3'b011: alu_control_o = ALU_SLT;
               default:        illegal_o = 1'b1;
            endcase
            // Register form only allows funct7 zero, or 0100000 for sub.
            if ((opcode_i == OPC_R) &&
                !((funct7_i == 7'b0000000) ||
                  ((funct7_i == 7'b0100000) && (funct3_i == 3'b000)))) begin
               illegal_o = 1'b1;
            end
         end
         OPC_LOAD, OPC_STORE, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: begin
            alu_control_o = ALU_PLUS;
         end
         OPC_BRANCH: begin
            alu_control_o = ALU_MINUS;
            if ((funct3_i != 3'b000) && (funct3_i != 3'b001)) begin
               illegal_o = 1'b1;
            end
         end
         default: illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_ctrl_stage.sv
// Decode stage producing ALU and downstream control. Decodes the IF/ID
// instruction, builds the sign-extended immediate, and registers the
// result into the control half of ID/EX with flush and stall support.
module alu_ctrl_stage
   import alu_ctrl_stage_pkg::*;
#(
   parameter int XLEN = 32
) (
   input logic     clk,
   input logic     rst,
   alu_ctrl_if.master bus
);

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   logic [4:0]      rd_field;
   logic [31:0]     instr;

   alu_op_e         dec_alu_op;
   logic            dec_illegal;

   logic [31:0]     imm32;
   logic [XLEN-1:0] sext_imm;

   ctrl_t           ctrl_d, ctrl_q;
   logic [XLEN-1:0] imm_d, imm_q;

   assign instr    = bus.instr;
   assign opcode   = instr[6:0];
   assign rd_field = instr[11:7];
   assign funct3   = instr[14:12];
   assign funct7   = instr[31:25];

   alu_decoder u_alu_decoder (
      .opcode_i      (opcode),
      .funct3_i      (funct3),
      .funct7_i      (funct7),
      .alu_control_o (dec_alu_op),
      .illegal_o     (dec_illegal)
   );

   // Immediate generator: pick the format by opcode, then sign-extend to XLEN.
   always_comb begin
      imm32 = '0;
      case (opcode)
         OPC_I, OPC_LOAD, OPC_JALR:
            imm32 = {{20{instr[31]}}, instr[31:20]};
         OPC_STORE:
            imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         OPC_BRANCH:
            imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                     instr[11:8], 1'b0};
         OPC_LUI, OPC_AUIPC:
            imm32 = {instr[31:12], 12'h000};
         OPC_JAL:
            imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                     instr[30:21], 1'b0};
         default: imm32 = '0;
      endcase
      sext_imm        = {XLEN{imm32[31]}};
      sext_imm[31:0]  = imm32;
   end

   // Control decode; empty slots and illegal encodings carry no side effects.
   always_comb begin
      ctrl_d = '0;
      imm_d  = '0;
      if (bus.instr_valid) begin
         ctrl_d.valid = 1'b1;
         if (dec_illegal) begin
            ctrl_d.illegal = 1'b1;
         end else begin
            ctrl_d.alu_control = dec_alu_op;
            imm_d              = sext_imm;
            ctrl_d.rd          = writes_rd(opcode) ? rd_field : 5'd0;
            // Writing x0 is architecturally a no-op, so suppress the enable.
            ctrl_d.reg_write   = writes_rd(opcode) && (rd_field != 5'd0);
            case (opcode)
               OPC_I: begin
                  ctrl_d.alu_src_imm = 1'b1;
               end
               OPC_LOAD: begin
                  ctrl_d.alu_src_imm = 1'b1;
                  ctrl_d.mem_read    = 1'b1;
                  ctrl_d.result_src  = RES_MEM;
               end
               OPC_STORE: begin
                  ctrl_d.alu_src_imm = 1'b1;
                  ctrl_d.mem_write   = 1'b1;
               end
               OPC_BRANCH: begin
                  ctrl_d.branch    = 1'b1;
                  ctrl_d.branch_ne = funct3[0];
               end
               OPC_LUI: begin
                  ctrl_d.alu_a_sel   = A_SEL_ZERO;
                  ctrl_d.alu_src_imm = 1'b1;
               end
               OPC_AUIPC: begin
                  ctrl_d.alu_a_sel   = A_SEL_PC;
                  ctrl_d.alu_src_imm = 1'b1;
               end
               OPC_JAL: begin
                  ctrl_d.alu_a_sel   = A_SEL_PC;
                  ctrl_d.alu_src_imm = 1'b1;
                  ctrl_d.result_src  = RES_PC4;
                  ctrl_d.jump        = 1'b1;
               end
               OPC_JALR: begin
                  ctrl_d.alu_src_imm = 1'b1;
                  ctrl_d.result_src  = RES_PC4;
                  ctrl_d.jump        = 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   // ID/EX control register: reset and flush insert a bubble, stall holds.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_q <= '0;
         imm_q  <= '0;
      end else if (bus.flush) begin
         ctrl_q <= '0;
         imm_q  <= '0;
      end else if (!bus.stall) begin
         ctrl_q <= ctrl_d;
         imm_q  <= imm_d;
      end
   end

   assign bus.alu_control = ctrl_q.alu_control;
   assign bus.alu_a_sel   = ctrl_q.alu_a_sel;
   assign bus.alu_src_imm = ctrl_q.alu_src_imm;
   assign bus.imm         = imm_q;
   assign bus.rd          = ctrl_q.rd;
   assign bus.reg_write   = ctrl_q.reg_write;
   assign bus.mem_read    = ctrl_q.mem_read;
   assign bus.mem_write   = ctrl_q.mem_write;
   assign bus.result_src  = ctrl_q.result_src;
   assign bus.branch      = ctrl_q.branch;
   assign bus.jump        = ctrl_q.jump;
   assign bus.branch_ne   = ctrl_q.branch_ne;
   assign bus.valid       = ctrl_q.valid;
   assign bus.illegal     = ctrl_q.illegal;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Scoreboard bench for alu_ctrl_stage: stimulus pushes the expected ID/EX
// contents per cycle, a monitor pops and compares after each rising edge.
module tb_alu_ctrl_stage;

   typedef struct packed {
      logic [2:0]  alu;
      logic [1:0]  asel;
      logic        simm;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic        rw;
      logic        mr;
      logic        mw;
      logic [1:0]  rsrc;
      logic        br;
      logic        jp;
      logic        bne;
      logic        v;
      logic        ill;
   } exp_t;

   logic clk;
   logic rst;
   int   checks   = 0;
   int   failures = 0;
   int   txn      = 0;
   exp_t exp_q[$];
   exp_t model_q = '0;

   alu_ctrl_if #(.XLEN(32)) bus ();

   alu_ctrl_stage #(.XLEN(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t sample();
      exp_t a;
      a.alu  = bus.alu_control;
      a.asel = bus.alu_a_sel;
      a.simm = bus.alu_src_imm;
      a.imm  = bus.imm;
      a.rd   = bus.rd;
      a.rw   = bus.reg_write;
      a.mr   = bus.mem_read;
      a.mw   = bus.mem_write;
      a.rsrc = bus.result_src;
      a.br   = bus.branch;
      a.jp   = bus.jump;
      a.bne  = bus.branch_ne;
      a.v    = bus.valid;
      a.ill  = bus.illegal;
      return a;
   endfunction

   function automatic logic [2:0] op_of_funct3(input logic [2:0] f3);
      if (f3 == 3'b111) return 3'b010;
      if (f3 == 3'b110) return 3'b011;
      if (f3 == 3'b010 || f3 == 3'b011) return 3'b101;
      return 3'b000;
   endfunction

   // Reference decode straight from the ISA rules.
   function automatic exp_t model(input logic [31:0] ins, input logic v);
      exp_t        e;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
      bit          legal;
      bit          has_rd;
      e      = '0;
      op     = ins[6:0];
      f3     = ins[14:12];
      f7     = ins[31:25];
      i_imm  = $signed(ins) >>> 20;
      s_imm  = {i_imm[31:5], ins[11:7]};
      b_imm  = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      u_imm  = ins & 32'hFFFF_F000;
      j_imm  = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      legal  = 1'b1;
      has_rd = 1'b0;
      if (!v) return e;
      e.v = 1'b1;
      case (op)
         7'b0110011: begin
            legal  = ((f7 == 7'h00) && (f3 inside {3'b000, 3'b010, 3'b011, 3'b110, 3'b111})) ||
                     ((f7 == 7'h20) && (f3 == 3'b000));
            e.alu  = (f7 == 7'h20) ? 3'b001 : op_of_funct3(f3);
            has_rd = 1'b1;
         end
         7'b0010011: begin
            legal  = f3 inside {3'b000, 3'b010, 3'b011, 3'b110, 3'b111};
            e.alu  = op_of_funct3(f3);
            e.simm = 1'b1; e.imm = i_imm; has_rd = 1'b1;
         end
         7'b0000011: begin
            e.simm = 1'b1; e.imm = i_imm; e.mr = 1'b1; e.rsrc = 2'b01; has_rd = 1'b1;
         end
         7'b0100011: begin
            e.simm = 1'b1; e.imm = s_imm; e.mw = 1'b1;
         end
         7'b1100011: begin
            legal = (f3 == 3'b000) || (f3 == 3'b001);
            e.alu = 3'b001; e.imm = b_imm; e.br = 1'b1; e.bne = (f3 == 3'b001);
         end
         7'b0110111: begin
            e.asel = 2'b10; e.simm = 1'b1; e.imm = u_imm; has_rd = 1'b1;
         end
         7'b0010111: begin
            e.asel = 2'b01; e.simm = 1'b1; e.imm = u_imm; has_rd = 1'b1;
         end
         7'b1101111: begin
            e.asel = 2'b01; e.simm = 1'b1; e.imm = j_imm; e.rsrc = 2'b10; e.jp = 1'b1;
            has_rd = 1'b1;
         end
         7'b1100111: begin
            e.simm = 1'b1; e.imm = i_imm; e.rsrc = 2'b10; e.jp = 1'b1; has_rd = 1'b1;
         end
         default: legal = 1'b0;
      endcase
      if (!legal) begin
         e     = '0;
         e.v   = 1'b1;
         e.ill = 1'b1;
         return e;
      end
      if (has_rd) begin
         e.rd = ins[11:7];
         e.rw = (ins[11:7] != 5'd0);
      end
      return e;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end else begin
         $display("check %s ok value=%h", nm, act);
      end
   endtask

   // Drive one cycle of inputs on the falling edge and queue the expected result.
   task automatic issue(input logic [31:0] ins, input logic v, input logic st,
                        input logic fl, input logic r);
      exp_t nxt;
      @(negedge clk);
      bus.instr       = ins;
      bus.instr_valid = v;
      bus.stall       = st;
      bus.flush       = fl;
      rst             = r;
      if (r || fl)    nxt = '0;
      else if (st)    nxt = model_q;
      else            nxt = model(ins, v);
      model_q = nxt;
      exp_q.push_back(nxt);
      if (r) begin
         #1;
         chk("rst_async_clear", 64'(sample()), 64'd0);
      end
   endtask

   task automatic post_edge();
      @(posedge clk);
      #2;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] ins;
      logic [6:0]  ops [10];
      ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
              7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0000000};
      ins = $urandom();
      ops[9] = 7'($urandom());
      ins[6:0] = ops[$urandom_range(0, 9)];
      if (ins[6:0] == 7'b0110011 && $urandom_range(0, 3) != 0)
         ins[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      if ($urandom_range(0, 7) == 0) ins[11:7] = 5'd0;
      return ins;
   endfunction

   // Monitor: after every rising edge compare the registered outputs.
   initial begin
      exp_t e;
      exp_t a;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = sample();
            checks++;
            txn++;
            if (a !== e) begin
               failures++;
               $display("FAIL scoreboard txn=%0d actual=%h required=%h", txn, a, e);
            end else begin
               $display("txn %0d ok v=%b ill=%b alu=%0d rd=%0d imm=%h",
                        txn, a.v, a.ill, a.alu, a.rd, a.imm);
            end
         end
      end
   end

   // Watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   // Stimulus: directed test-plan vectors, then randomized traffic.
   initial begin
      rst             = 1'b1;
      bus.instr       = '0;
      bus.instr_valid = 1'b0;
      bus.stall       = 1'b0;
      bus.flush       = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_state", 64'(sample()), 64'd0);

      issue(32'h002081B3, 1'b1, 1'b0, 1'b0, 1'b0);
      post_edge();
      chk("add_alu", 64'(bus.alu_control), 64'd0);
      chk("add_src_imm", 64'(bus.alu_src_imm), 64'd0);
      chk("add_reg_write", 64'(bus.reg_write), 64'd1);
      chk("add_rd", 64'(bus.rd), 64'd3);
      chk("add_valid", 64'(bus.valid), 64'd1);

      issue(32'h402081B3, 1'b1, 1'b0, 1'b0, 1'b0);
      post_edge();
      chk("sub_alu", 64'(bus.alu_control), 64'd1);

      issue(32'h0020C1B3, 1'b1, 1'b0, 1'b0, 1'b0);
      post_edge();
      chk("xor_illegal", 64'(bus.illegal), 64'd1);
      chk("xor_reg_write", 64'(bus.reg_write), 64'd0);

      issue(32'hFFF00293, 1'b1, 1'b0, 1'b0, 1'b0);
      post_edge();
      chk("addi_alu", 64'(bus.alu_control), 64'd0);
      chk("addi_src_imm", 64'(bus.alu_src_imm), 64'd1);
      chk("addi_imm", 64'(bus.imm), 64'hFFFF_FFFF);
      chk("addi_rd", 64'(bus.rd), 64'd5);

      issue(32'h00208463, 1'b1, 1'b0, 1'b0, 1'b0);
      post_edge();
      chk("beq_alu", 64'(bus.alu_control), 64'd1);
      chk("beq_branch", 64'(bus.branch), 64'd1);
      chk("beq_branch_ne", 64'(bus.branch_ne), 64'd0);
      chk("beq_imm", 64'(bus.imm), 64'd8);
      chk("beq_reg_write", 64'(bus.reg_write), 64'd0);

      // Stall holds the add while new instructions wait on the input.
      issue(32'h002081B3, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) issue(32'hFFF00293, 1'b1, 1'b1, 1'b0, 1'b0);
      post_edge();
      chk("stall_hold_rd", 64'(bus.rd), 64'd3);
      chk("stall_hold_imm", 64'(bus.imm), 64'd0);
      issue(32'h402081B3, 1'b1, 1'b1, 1'b1, 1'b0);
      post_edge();
      chk("stall_flush_bubble", 64'(sample()), 64'd0);

      // Asynchronous reset while a real instruction sits in ID/EX.
      issue(32'h002081B3, 1'b1, 1'b0, 1'b0, 1'b0);
      issue(32'h002081B3, 1'b1, 1'b0, 1'b0, 1'b1);
      issue(32'h402081B3, 1'b1, 1'b0, 1'b0, 1'b0);
      post_edge();
      chk("rst_resume_alu", 64'(bus.alu_control), 64'd1);
      chk("rst_resume_valid", 64'(bus.valid), 64'd1);

      for (int i = 0; i < 300; i++) begin
         issue(rand_instr(), ($urandom_range(0, 7) != 0), ($urandom_range(0, 5) == 0),
               ($urandom_range(0, 9) == 0), ($urandom_range(0, 49) == 0));
      end
      issue(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

      repeat (3) @(posedge clk);
      #3;
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_ctrl_stage.md
# alu_ctrl_stage

Decode-side producer of the ALU control interface for the pipelined RISC-V core. Decodes the 32-bit instruction held in IF/ID into the 3-bit ALU operation code, operand selects, immediate and write-back controls, and registers them into the control half of the ID/EX pipeline register. Supports stall (hold) and flush (bubble insertion). Its outputs feed the ALU and the downstream EX/MEM/WB control path directly.

## Interface
Parameters:
- XLEN, 32, datapath and immediate width.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- instr  input  32  instruction from IF/ID.
- instr_valid  input  1  IF/ID slot holds a real instruction.
- stall  input  1  hold all registered outputs.
- flush  input  1  replace the next registered value with a bubble.
- alu_control  output  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 101 set-less-than.
- alu_a_sel  output  2  A operand: 00 rs1, 01 pc, 10 zero.
- alu_src_imm  output  1  B operand is imm (1) or rs2 (0).
- imm  output  32  sign-extended immediate.
- rd  output  5  destination register.
- reg_write  output  1  write-back enable.
- mem_read / mem_write  output  1 each  data-memory controls.
- result_src  output  2  00 ALU, 01 memory, 10 pc+4.
- branch / jump  output  1 each  beq/bne and jal/jalr indicators.
- branch_ne  output  1  branch taken on ALU zero==0.
- valid  output  1  ID/EX slot holds a real instruction.
- illegal  output  1  decoded instruction unsupported.

## Operation
- Decode by opcode: R 0110011, I-ALU 0010011, load 0000011, store 0100011, branch 1100011, lui 0110111, auipc 0010111, jal 1101111, jalr 1100111.
- R/I funct3: 000 add (sub if R and funct7[5]=1), 111 and, 110 or, 010 and 011 both set-less-than. funct3 001/100/101 and any other funct7 value: illegal.
- load/store/jalr/auipc/lui: add. branch: sub; funct3 000 beq, 001 bne, others illegal.
- lui: a_sel zero, imm U-type. auipc: a_sel pc. jal: a_sel pc, result_src 10.
- Immediates: I, S, B, U, J formats, sign-extended from instr[31]; B/J bit 0 forced 0.
- Illegal or instr_valid=0: all side-effect controls (reg_write, mem_*, branch, jump) 0; illegal asserted only when instr_valid=1.
- rd=0 forces reg_write=0.

## Timing
- Registered outputs, latency one cycle: decode of instr at edge N visible after edge N.
- rst: every output 0 (alu_control 000, imm 0, valid 0) immediately, independent of clk; reset mid-stall returns to bubble.
- Priority per edge: rst > flush > stall > load.
- flush: registers zeroed (bubble, valid 0) even if stall high.
- stall without flush: all outputs hold exactly, including imm and illegal.
- Back-to-back instructions: one new decode per cycle, no bubbles inserted internally.

## Structure
- Shared package: ALU op codes (PLUS 000, MINUS 001, AND 010, OR 011, SLT 101), opcode constants, a_sel and result_src encodings.
- Sub-module alu_decoder: combinational opcode/funct3/funct7 to alu_control + illegal; top holds immediate generator and ID/EX control registers.

## Test plan
- 0x002081B3 (add x3,x1,x2) -> next cycle alu_control 000, alu_src_imm 0, reg_write 1, rd 3, valid 1.
- 0x402081B3 (sub) -> 001; 0x0020C1B3 (xor) -> illegal 1, reg_write 0.
- 0xFFF00293 (addi x5,x0,-1) -> alu_control 000, alu_src_imm 1, imm 0xFFFFFFFF, rd 5.
- 0x00208463 (beq x1,x2,+8) -> alu_control 001, branch 1, branch_ne 0, imm 0x00000008, reg_write 0.
- add decoded, then stall 3 cycles with new instr on input -> outputs unchanged; stall+flush same cycle -> valid 0, all controls 0.
- rst asserted mid-cycle while valid 1 -> all outputs 0 before next edge; released -> normal decode resumes next edge.
